inst_fetch: RTL

Front-end fetch sequencer that drives the PC block's command interface and consumes its pc output. It issues one instruction-memory read at a time for the current pc and buffers each {pc, instruction} pair in a small FIFO toward decode. It advances the PC with INC on each accepted request and applies branch/jump redirects with LOAD, discarding any fetch that was in flight when the redirect occurred.

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/inst_fetch_fifo.sv | 59 +++++
 rtl/inst_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types for the fetch front end: address and PC-command types plus the fetch buffer entry.
// The optional same-cycle bypass is selected with INST_FETCH_BYPASS_EN in inst_fetch.sv.
package Parameters;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] InstStartFrom = 32'h0000_0000;
endpackage

package Types;
    import Parameters::*;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

package PCType;
    typedef enum logic [1:0] {HOLD, INC, INC_OFFSET, LOAD} pc_cmd_t;
endpackage

package FetchType;
    import Types::*;
    localparam int INST_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
    typedef logic [INST_W-1:0] inst_t;
    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// Small register FIFO of {pc, instruction} entries between fetch and decode.
// Flush empties it in one cycle; pushes to a full FIFO and pops from an empty one are ignored.
module fetch_fifo
    import FetchType::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count_reg != FULL);
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/inst_fetch.sv
// Fetch sequencer: one outstanding imem read, PC advance/redirect commands, buffered output to decode.
// Define INST_FETCH_BYPASS_EN to forward a response straight to the output when the buffer is empty.
module inst_fetch
    import Parameters::*, Types::*, PCType::*, FetchType::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  addr_t             pc,
    output pc_cmd_t           pc_cmd,
    output addr_t             load_pc,
    input  logic              redirect_valid,
    input  addr_t             redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output addr_t             imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output addr_t             out_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = FIFO_DEPTH[CW-1:0];

    fetch_state_t  state_reg;
    logic          drop_reg;
    logic          req_valid_reg;
    addr_t         pending_pc_reg;
    logic          handshake;
    logic          rsp_take;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign handshake = (state_reg == REQ) && req_valid_reg && imem_req_ready;
    assign rsp_take  = (state_reg == WAIT) && imem_rsp_valid && !redirect_valid;

`ifdef INST_FETCH_BYPASS_EN
    assign bypass = rsp_take && !drop_reg && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push       = rsp_take && !drop_reg && !(bypass && out_ready);
    assign out_valid  = (count != '0) || bypass;
    assign pop        = out_ready && (count != '0);
    assign push_entry = '{pc: pending_pc_reg, inst: imem_rsp_data};
    assign out_inst   = bypass ? imem_rsp_data : head.inst;
    assign out_pc     = bypass ? pending_pc_reg : head.pc;

    assign imem_req_valid = req_valid_reg;
    assign imem_addr      = pc;

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    // Redirect wins over INC; the handshake in that cycle fetched a stale pc and is dropped later.
    always_comb begin
        pc_cmd  = HOLD;
        load_pc = '0;
        if (!rst && redirect_valid) begin
            pc_cmd  = LOAD;
            load_pc = redirect_pc;
        end else if (handshake) begin
            pc_cmd = INC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            drop_reg       <= 1'b0;
            req_valid_reg  <= 1'b0;
            pending_pc_reg <= InstStartFrom;
        end else begin
            if (handshake) pending_pc_reg <= pc;
            if (redirect_valid) begin
                // A response landing in the redirect cycle closes the old read, so nothing is left to drop.
                if (((state_reg == WAIT) && !imem_rsp_valid) || handshake) begin
                    drop_reg      <= 1'b1;
                    state_reg     <= WAIT;
                    req_valid_reg <= 1'b0;
                end else begin
                    drop_reg      <= 1'b0;
                    state_reg     <= REQ;
                    req_valid_reg <= 1'b1;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (count < FULL) begin
                            state_reg     <= REQ;
                            req_valid_reg <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (handshake) begin
                            state_reg     <= WAIT;
                            req_valid_reg <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (imem_rsp_valid) begin
                            drop_reg <= 1'b0;
                            if (count_next < FULL) begin
                                state_reg     <= REQ;
                                req_valid_reg <= 1'b1;
                            end else begin
                                state_reg     <= IDLE;
                                req_valid_reg <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_reg     <= IDLE;
                        req_valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );
endmodule
